// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: instruction field positions, fetch states, PC helpers
//
// Purpose: single source of truth for the instruction word layout and the fetch
//          state encoding, reused by the fetch stage and the datapath decoders.
// Contents:
//   PC_W, INSTR_W           widths of the program counter and instruction word
//   DEFAULT_HALT_WORD       instruction word that stops fetching
//   *_HI / *_LO, S_BIT      bit positions of the decoded fields
//   fetch_state_e           fetch sequencer states
//   pc_next()               16-bit wrapping PC increment

package cpu_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    localparam int COND_HI   = 31;
    localparam int COND_LO   = 28;
    localparam int OPCODE_HI = 27;
    localparam int OPCODE_LO = 24;
    localparam int S_BIT     = 23;
    localparam int DEST_HI   = 22;
    localparam int DEST_LO   = 19;
    localparam int SRC2_HI   = 18;
    localparam int SRC2_LO   = 15;
    localparam int SRC1_HI   = 14;
    localparam int SRC1_LO   = 11;
    localparam int SHROR_HI  = 10;
    localparam int SHROR_LO  = 6;
    // The move immediate overlaps source_2/source_1/shift; its low end is the
    // lowest bit any field uses.
    localparam int IVMOV_HI  = 18;
    localparam int IVMOV_LO  = 3;

    typedef enum logic [2:0] {
        FETCH_IDLE  = 3'd0,
        FETCH_REQ   = 3'd1,
        FETCH_WAIT  = 3'd2,
        FETCH_VALID = 3'd3,
        FETCH_HALT  = 3'd4
    } fetch_state_e;

    // Unsigned increment; 16'hFFFF rolls over to 16'h0000.
    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - pure combinational slicer of an instruction word into its fields
//
// Purpose: split an instruction word into the datapath control fields.
// Ports:
//   instr_i         in  [31:3]  instruction word (bits 2:0 belong to no field)
//   cond_o          out 4       condition code
//   opcode_o        out 4       operation
//   s_o             out 1       set-flags bit
//   dest_o          out 4       destination register
//   src2_o          out 4       second source register
//   src1_o          out 4       first source register
//   iv_shift_ror_o  out 5       shift / rotate amount
//   iv_mov_o        out 16      move immediate

module instr_decode
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:IVMOV_LO]  instr_i,
    output logic [3:0]                 cond_o,
    output logic [3:0]                 opcode_o,
    output logic                       s_o,
    output logic [3:0]                 dest_o,
    output logic [3:0]                 src2_o,
    output logic [3:0]                 src1_o,
    output logic [4:0]                 iv_shift_ror_o,
    output logic [15:0]                iv_mov_o
);

    assign cond_o         = instr_i[COND_HI:COND_LO];
    assign opcode_o       = instr_i[OPCODE_HI:OPCODE_LO];
    assign s_o            = instr_i[S_BIT];
    assign dest_o         = instr_i[DEST_HI:DEST_LO];
    assign src2_o         = instr_i[SRC2_HI:SRC2_LO];
    assign src1_o         = instr_i[SRC1_HI:SRC1_LO];
    assign iv_shift_ror_o = instr_i[SHROR_HI:SHROR_LO];
    assign iv_mov_o       = instr_i[IVMOV_HI:IVMOV_LO];

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - sequential fetch stage: PC, RAM read sequencing, valid/ready presentation
//
// Purpose: owns the program counter, issues reads to the instruction RAM, captures
//          the returned word and presents it with its decoded fields under a
//          valid/ready handshake. Supports branch redirect and a halt word.
// Parameters:
//   RAM_LATENCY  cycles from request to RAM data valid (1..4)
//   START_ADDR   PC after reset
//   HALT_WORD    instruction word that stops fetching until reset
// Ports:
//   Clk, Reset                 clock (rising edge), asynchronous active-high reset
//   Start                      leave IDLE and begin fetching
//   Enable, RW_ram, Address_in RAM request (RW_ram is always read)
//   Out                        RAM read data
//   Instr_valid, Instr_ready   presentation handshake
//   Instruction + fields, pc   held instruction, its decoded fields and its address
//   Branch_taken, Branch_target redirect request
//   Halted                     fetch stopped on HALT_WORD

module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int                 RAM_LATENCY = 1,
    parameter logic [PC_W-1:0]    START_ADDR  = 16'h0000,
    parameter logic [INSTR_W-1:0] HALT_WORD   = DEFAULT_HALT_WORD
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    output logic                Enable,
    output logic                RW_ram,
    output logic [PC_W-1:0]     Address_in,
    input  logic [INSTR_W-1:0]  Out,
    output logic                Instr_valid,
    input  logic                Instr_ready,
    output logic [INSTR_W-1:0]  Instruction,
    output logic [3:0]          Cond,
    output logic [3:0]          OpCode,
    output logic                S,
    output logic [3:0]          destination,
    output logic [3:0]          source_2,
    output logic [3:0]          source_1,
    output logic [4:0]          IV_ShiftRor,
    output logic [15:0]         IV_Mov,
    output logic [PC_W-1:0]     pc,
    input  logic                Branch_taken,
    input  logic [PC_W-1:0]     Branch_target,
    output logic                Halted
);

    // WAIT counts down from this value; the edge leaving count 0 captures RAM data.
    localparam logic [1:0] LAST_WAIT = 2'(RAM_LATENCY - 1);

    fetch_state_e        state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [1:0]          wait_cnt_q, wait_cnt_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= START_ADDR;
            wait_cnt_q <= 2'd0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wait_cnt_q <= wait_cnt_d;
            instr_q    <= instr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        wait_cnt_d = wait_cnt_q;
        instr_d    = instr_q;

        case (state_q)
            FETCH_IDLE: begin
                if (Start) begin
                    state_d = FETCH_REQ;
                end
            end

            FETCH_REQ: begin
                if (Branch_taken) begin
                    pc_d    = Branch_target;
                    state_d = FETCH_REQ;
                end else begin
                    wait_cnt_d = LAST_WAIT;
                    state_d    = FETCH_WAIT;
                end
            end

            FETCH_WAIT: begin
                // A redirect abandons the read in flight, including on the
                // capture edge itself, so the stale word never reaches instr_q.
                if (Branch_taken) begin
                    pc_d    = Branch_target;
                    state_d = FETCH_REQ;
                end else if (wait_cnt_q == 2'd0) begin
                    if (Out == HALT_WORD) begin
                        state_d = FETCH_HALT;
                    end else begin
                        instr_d = Out;
                        state_d = FETCH_VALID;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end

            FETCH_VALID: begin
                // Branch has priority over an accept in the same cycle.
                if (Branch_taken) begin
                    pc_d    = Branch_target;
                    state_d = FETCH_REQ;
                end else if (Instr_ready) begin
                    pc_d    = pc_next(pc_q);
                    state_d = FETCH_REQ;
                end
            end

            FETCH_HALT: begin
                state_d = FETCH_HALT;
            end

            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    assign Enable      = (state_q == FETCH_REQ) || (state_q == FETCH_WAIT);
    assign RW_ram      = 1'b1;
    assign Address_in  = pc_q;
    assign pc          = pc_q;
    assign Instr_valid = (state_q == FETCH_VALID);
    assign Halted      = (state_q == FETCH_HALT);
    assign Instruction = instr_q;

    instr_decode u_decode (
        .instr_i        (instr_q[INSTR_W-1:IVMOV_LO]),
        .cond_o         (Cond),
        .opcode_o       (OpCode),
        .s_o            (S),
        .dest_o         (destination),
        .src2_o         (source_2),
        .src1_o         (source_1),
        .iv_shift_ror_o (IV_ShiftRor),
        .iv_mov_o       (IV_Mov)
    );

endmodule
